pulpino_mini_top: RTL and testbench

Reduced PULPino top that handles GPIO pin interrupts and reports them, with no processor core.
- Detects configured edges on gpio_in and queues one event per detected edge.
- Reports each event as an 8N1 byte on uart_tx and keeps an event count on gpio_out.
- Raises the end-of-computation flag on gpio_out[8] once a target number of events has been reported.
- Sits where the full pulpino_top sits, facing the same GPIO/UART pads, for interrupt bring-up.

---
 rtl/pulpino_mini_top.sv | 171 +++++++++++++++++
 tb/tb_pulpino_mini_top.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulpino_mini_top.sv
// pulpino_mini_top: processor-less PULPino shell for GPIO interrupt bring-up.
// Each configured edge on gpio_in becomes one event. Every event is reported
// as an 8N1 byte on uart_tx and counted on gpio_out[7:0]. gpio_out[8] is set
// once DONE_COUNT events have been reported.
// Optional build macro: UART_CTS_EN makes new frames wait for uart_cts low.
module pulpino_mini_top #(
  parameter int          BAUD_DIV      = 32,
  parameter logic [31:0] IRQ_RISE_MASK = 32'h0000_0006,
  parameter logic [31:0] IRQ_FALL_MASK = 32'h0000_0002,
  parameter int          DONE_COUNT    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_enable_i,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_dir,
  output logic        uart_tx,
  input  logic        uart_cts,
  output logic        uart_rts,
  output logic        uart_dtr
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic [31:0] s1, s2, s3;
  logic [31:0] rise_pend, fall_pend;
  logic [31:0] rise_edge, fall_edge;
  logic [31:0] clr_rise, clr_fall;
  tx_state_t   state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        tx_reg;
  logic [7:0]  evt_count;
  logic        done;
  logic        baud_end, tx_free, any_pend, cts_ok, load;
  logic [4:0]  sel_pin;
  logic        sel_rise;
  logic [7:0]  load_byte;

`ifdef UART_CTS_EN
  assign cts_ok = ~uart_cts;
`else
  logic unused_cts;
  assign unused_cts = uart_cts;
  assign cts_ok     = 1'b1;
`endif

  assign rise_edge = s2 & ~s3 & IRQ_RISE_MASK;
  assign fall_edge = ~s2 & s3 & IRQ_FALL_MASK;
  assign baud_end  = (baud_cnt == BW'(BAUD_DIV - 1));
  // The last stop-bit cycle counts as free so frames can run back-to-back.
  assign tx_free   = (state == IDLE) || ((state == STOP) && baud_end);
  assign any_pend  = |(rise_pend | fall_pend);
  assign load      = tx_free && any_pend && cts_ok;
  assign sel_rise  = rise_pend[sel_pin];
  assign load_byte = {sel_rise, 2'b00, sel_pin};
  assign clr_rise  = (load && sel_rise)  ? (32'd1 << sel_pin) : 32'd0;
  assign clr_fall  = (load && !sel_rise) ? (32'd1 << sel_pin) : 32'd0;

  // Pick the lowest pin index with any pending edge.
  always_comb begin
    // NOTE: default assignment first so no path leaves sel_pin unassigned (no latch).
    sel_pin = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (rise_pend[i] || fall_pend[i]) sel_pin = 5'(i);
    end
  end

  // Two-flop synchronizer plus history stage for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      // NOTE: non-blocking so each stage takes the previous stage's old value.
      s1 <= gpio_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Pending flags: set by enabled edges, cleared by arbitration; set wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_pend <= '0;
      fall_pend <= '0;
    end else begin
      rise_pend <= (rise_pend & ~clr_rise) | (fetch_enable_i ? rise_edge : 32'd0);
      fall_pend <= (fall_pend & ~clr_fall) | (fetch_enable_i ? fall_edge : 32'd0);
    end
  end

  // UART transmitter: start bit, 8 data bits LSB first, one stop bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_reg   <= 1'b1;
    end else if (load) begin
      state    <= START;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= load_byte;
      tx_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: baud_cnt <= '0;
        START: begin
          if (baud_end) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_reg   <= shift[0];
            shift    <= shift >> 1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state  <= STOP;
              tx_reg <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_reg  <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            state    <= IDLE;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Event counter and sticky done flag, advanced on every byte load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_count <= '0;
      done      <= 1'b0;
    end else if (load) begin
      evt_count <= evt_count + 8'd1;
      if (8'(evt_count + 8'd1) == 8'(DONE_COUNT)) done <= 1'b1;
    end
  end

  assign uart_tx  = tx_reg;
  assign gpio_out = {23'd0, done, evt_count};
  assign gpio_dir = 32'h0000_01FF;
  assign uart_rts = 1'b0;
  assign uart_dtr = 1'b0;

endmodule

// File: tb/tb_pulpino_mini_top.sv
// Testbench for pulpino_mini_top: directed scenarios plus randomized edge
// bursts, checked against a byte-level model of the event rules and a UART
// receiver that decodes uart_tx independently.
module tb_pulpino_mini_top;

  localparam int          BAUD_DIV   = 32;
  localparam logic [31:0] RISE_MASK  = 32'h0000_0006;
  localparam logic [31:0] FALL_MASK  = 32'h0000_0002;
  localparam int          DONE_COUNT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_enable_i = 1'b1;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_out, gpio_dir;
  logic        uart_tx, uart_cts = 1'b0, uart_rts, uart_dtr;

  pulpino_mini_top #(
    .BAUD_DIV(BAUD_DIV), .IRQ_RISE_MASK(RISE_MASK),
    .IRQ_FALL_MASK(FALL_MASK), .DONE_COUNT(DONE_COUNT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_enable_i(fetch_enable_i),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_dir(gpio_dir),
    .uart_tx(uart_tx), .uart_cts(uart_cts), .uart_rts(uart_rts),
    .uart_dtr(uart_dtr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; int start; bit ok; } rx_t;
  rx_t        rx_q[$];
  logic [7:0] exp_q[$];
  logic [31:0] cur_gpio = '0;
  int loads = 0;
  int chg_cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent 8N1 receiver, sampling mid-bit on the falling clock edge.
  initial begin
    rx_t r;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        r.start = cyc;
        r.ok = 1'b1;
        repeat (BAUD_DIV / 2 - 1) @(negedge clk);
        if (uart_tx !== 1'b0) r.ok = 1'b0;
        for (int b = 0; b < 8; b++) begin
          repeat (BAUD_DIV) @(negedge clk);
          r.data[b] = uart_tx;
        end
        repeat (BAUD_DIV) @(negedge clk);
        if (uart_tx !== 1'b1) r.ok = 1'b0;
        rx_q.push_back(r);
      end
    end
  end

  // Expected bytes for a pad change old -> nv, in lowest-pin, rise-first order.
  task automatic model_edges(input logic [31:0] old, input logic [31:0] nv, input bit fe);
    for (int p = 0; p < 32; p++) begin
      if (fe && nv[p] && !old[p] && RISE_MASK[p]) exp_q.push_back({1'b1, 2'b00, 5'(p)});
      if (fe && !nv[p] && old[p] && FALL_MASK[p]) exp_q.push_back({1'b0, 2'b00, 5'(p)});
    end
  endtask

  task automatic drive_toggle(input logic [31:0] toggles);
    logic [31:0] nv;
    nv = cur_gpio ^ toggles;
    model_edges(cur_gpio, nv, fetch_enable_i);
    @(negedge clk);
    gpio_in  = nv;
    cur_gpio = nv;
    chg_cyc  = cyc;
  endtask

  task automatic reset_dut(input logic [31:0] init);
    @(negedge clk);
    rst_n   = 1'b0;
    gpio_in = init;
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    chg_cyc  = cyc;
    loads    = 0;
    cur_gpio = init;
    exp_q.delete();
    model_edges(32'd0, init, 1'b1);
  endtask

  // Receive every expected byte, then confirm nothing extra and the counters.
  task automatic collect(input string tag, input bit chk_lat);
    int prev_start = 0;
    bit first = 1'b1;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      rx_t r;
      int n = 0;
      e = exp_q.pop_front();
      while (rx_q.size() == 0 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check({tag, "_rx_present"}, 32'(rx_q.size() != 0), 32'd1);
      if (rx_q.size() == 0) begin
        exp_q.delete();
        break;
      end
      r = rx_q.pop_front();
      loads++;
      check({tag, "_byte"}, 32'(r.data), 32'(e));
      check({tag, "_framing"}, 32'(r.ok), 32'd1);
      if (first && chk_lat) check({tag, "_latency"}, r.start - chg_cyc, 32'd4);
      if (!first) check({tag, "_b2b_gap"}, r.start - prev_start, 10 * BAUD_DIV);
      prev_start = r.start;
      first = 1'b0;
    end
    repeat (400) @(negedge clk);
    check({tag, "_no_extra"}, 32'(rx_q.size()), 32'd0);
    rx_q.delete();
    check({tag, "_count"}, 32'(gpio_out[7:0]), 32'(loads % 256));
    check({tag, "_done"}, 32'(gpio_out[8]), 32'(loads >= DONE_COUNT));
    check({tag, "_upper"}, 32'(gpio_out[31:9]), 32'd0);
  endtask

  initial begin
    // 1: reset state
    reset_dut(32'd0);
    #1;
    check("rst_gpio_out", gpio_out, 32'd0);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("gpio_dir", gpio_dir, 32'h0000_01FF);
    check("rts_dtr", 32'({uart_rts, uart_dtr}), 32'd0);
    repeat (20) @(negedge clk);
    check("idle_uart_tx", 32'(uart_tx), 32'd1);

    // 2: pin1 rise
    drive_toggle(32'h2);
    collect("pin1_rise", 1'b1);

    // 3: pin1 fall, pin1 rise, pin2 rise -> count reaches DONE_COUNT
    drive_toggle(32'h2);
    collect("pin1_fall", 1'b1);
    drive_toggle(32'h2);
    collect("pin1_rise2", 1'b1);
    drive_toggle(32'h4);
    collect("pin2_rise", 1'b1);

    // 4: both low together, then both rise together -> back-to-back frames
    drive_toggle(32'h6);
    collect("both_fall", 1'b1);
    drive_toggle(32'h6);
    collect("both_rise", 1'b1);

    // 5: disabled detection and an unmasked pin
    @(negedge clk); fetch_enable_i = 1'b0;
    repeat (5) @(negedge clk);
    drive_toggle(32'h2);
    repeat (20) @(negedge clk);
    drive_toggle(32'h2);
    collect("fe_off", 1'b1);
    @(negedge clk); fetch_enable_i = 1'b1;
    repeat (5) @(negedge clk);
    drive_toggle(32'h8);
    collect("pin3", 1'b1);

    // Pad high at reset release counts as a rising edge
    reset_dut(32'h4);
    collect("rst_high_pin2", 1'b1);

    // Reset in the middle of a frame
    reset_dut(32'd0);
    collect("rst_clean", 1'b1);
    drive_toggle(32'h6);
    exp_q.delete();
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    gpio_in = 32'd0;
    @(posedge clk); #1;
    check("midrst_uart_tx", 32'(uart_tx), 32'd1);
    check("midrst_gpio_out", gpio_out, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    cur_gpio = 32'd0;
    loads = 0;
    repeat (500) @(negedge clk);
    rx_q.delete();
    collect("midrst_after", 1'b1);

`ifdef UART_CTS_EN
    // 6: clear-to-send holds the transmitter
    begin
      bit held = 1'b1;
      @(negedge clk); uart_cts = 1'b1;
      drive_toggle(32'h4);
      repeat (500) begin
        @(negedge clk);
        if (uart_tx !== 1'b1) held = 1'b0;
      end
      check("cts_hold", 32'(held), 32'd1);
      uart_cts = 1'b0;
      collect("cts_release", 1'b0);
    end
`else
    // uart_cts is ignored in this build
    @(negedge clk); uart_cts = 1'b1;
    drive_toggle(32'h4);
    collect("cts_ignored", 1'b1);
    uart_cts = 1'b0;
`endif

    // Randomized single/double pin changes with random enable
    for (int it = 0; it < 24; it++) begin
      logic [31:0] t;
      @(negedge clk); fetch_enable_i = ($urandom_range(0, 3) != 0);
      repeat (5) @(negedge clk);
      t = 32'd1 << $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) t = t | (32'd1 << $urandom_range(0, 5));
      drive_toggle(t);
      collect("rand", 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got cycle %0d required finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
